// File: rtl/cr_had_sync_tx.sv
// ============================================================================
// Module   : cr_had_sync_tx
// Purpose  : clk2-side lossless event transmitter over a four-phase req/ack
//            handshake toward a clk1-domain receiver.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module cr_had_sync_tx #(
    parameter int CNT_W = 4
) (
    input  logic             clk2,
    input  logic             rst2_b,
    input  logic             evt_in,
    input  logic             ack_in,
    output logic             req_out,
    output logic             busy_out,
    output logic             done_out,
    output logic             ovf_out,
    output logic [CNT_W-1:0] pend_out
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_REQ   = 2'd1,
        ST_ACKLO = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] PEND_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] PEND_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t           state_q, state_d;
    logic             ack_ff1_q, ack_ff2_q;
    logic             req_q, req_d;
    logic             done_q, done_d;
    logic             ovf_q, ovf_d;
    logic             busy_q, busy_d;
    logic [CNT_W-1:0] pend_q, pend_d;

    logic             ack_s;
    logic             start;
    logic             acc;

    always_comb begin
        ack_s   = ack_ff2_q;
        start   = (state_q == ST_IDLE) && !ack_s && (evt_in || (pend_q != '0));
        // A full counter still accepts an event when a start frees a slot.
        ovf_d   = evt_in && (pend_q == PEND_MAX) && !start;
        acc     = evt_in && !ovf_d;

        case ({acc, start})
            2'b10:   pend_d = pend_q + PEND_ONE;
            2'b01:   pend_d = pend_q - PEND_ONE;
            default: pend_d = pend_q;
        endcase

        state_d = state_q;
        req_d   = req_q;
        done_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_REQ;
                    req_d   = 1'b1;
                end
            end
            ST_REQ: begin
                if (ack_s) begin
                    state_d = ST_ACKLO;
                    req_d   = 1'b0;
                end
            end
            ST_ACKLO: begin
                if (!ack_s) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                req_d   = 1'b0;
            end
        endcase

        busy_d = (state_d != ST_IDLE) || (pend_d != '0);
    end

    always_ff @(posedge clk2 or negedge rst2_b) begin
        if (!rst2_b) begin
            state_q   <= ST_IDLE;
            ack_ff1_q <= 1'b0;
            ack_ff2_q <= 1'b0;
            req_q     <= 1'b0;
            done_q    <= 1'b0;
            ovf_q     <= 1'b0;
            busy_q    <= 1'b0;
            pend_q    <= '0;
        end else begin
            state_q   <= state_d;
            ack_ff1_q <= ack_in;
            ack_ff2_q <= ack_ff1_q;
            req_q     <= req_d;
            done_q    <= done_d;
            ovf_q     <= ovf_d;
            busy_q    <= busy_d;
            pend_q    <= pend_d;
        end
    end

    assign req_out  = req_q;
    assign done_out = done_q;
    assign ovf_out  = ovf_q;
    assign busy_out = busy_q;
    assign pend_out = pend_q;

endmodule

`default_nettype wire

// File: tb/tb_cr_had_sync_tx.sv
// ============================================================================
// Module   : tb_cr_had_sync_tx
// Purpose  : Directed and randomized self-checking bench for cr_had_sync_tx.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_cr_had_sync_tx;

    localparam int CNT_W = 4;

    logic             clk2 = 1'b0;
    logic             rst2_b;
    logic             evt_in;
    logic             ack_in;
    logic             req_out;
    logic             busy_out;
    logic             done_out;
    logic             ovf_out;
    logic [CNT_W-1:0] pend_out;

    int total = 0;
    int bad   = 0;

    // Observation counters and the bench's own view of the two-flop ack delay.
    int   done_cnt = 0;
    int   ovf_cnt  = 0;
    int   pend_max = 0;
    logic h1 = 1'b0, h2 = 1'b0, h3 = 1'b0;
    logic req_prev = 1'b0;

    // Bench receiver: answers req after rx_up cycles and releases after rx_dn.
    bit rx_auto = 1'b0;
    bit rx_rand = 1'b0;
    int rx_up   = 2;
    int rx_dn   = 2;
    int rx_cnt  = 0;

    int base_done;
    int base_ovf;
    int n_evt;

    always #5 clk2 = ~clk2;

    cr_had_sync_tx #(.CNT_W(CNT_W)) dut (
        .clk2     (clk2),
        .rst2_b   (rst2_b),
        .evt_in   (evt_in),
        .ack_in   (ack_in),
        .req_out  (req_out),
        .busy_out (busy_out),
        .done_out (done_out),
        .ovf_out  (ovf_out),
        .pend_out (pend_out)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic step(input bit e);
        @(posedge clk2);
        if (!rst2_b) begin
            h1 = 1'b0; h2 = 1'b0; h3 = 1'b0;
        end else begin
            h3 = h2; h2 = h1; h1 = ack_in;
        end
        #1;
        if (rst2_b) begin
            // A req edge is legal only against the synchronized ack seen before it.
            if (req_out !== req_prev)
                chk("req_edge_vs_ack_s", 32'(h3), 32'(!req_out));
            if (done_out) done_cnt++;
            if (ovf_out)  ovf_cnt++;
            if (int'(pend_out) > pend_max) pend_max = int'(pend_out);
        end
        req_prev = req_out;
        if (rx_auto) begin
            if (req_out && !ack_in) begin
                rx_cnt++;
                if (rx_cnt >= rx_up) begin
                    ack_in = 1'b1;
                    rx_cnt = 0;
                    if (rx_rand) rx_dn = $urandom_range(1, 6);
                end
            end else if (!req_out && ack_in) begin
                rx_cnt++;
                if (rx_cnt >= rx_dn) begin
                    ack_in = 1'b0;
                    rx_cnt = 0;
                    if (rx_rand) rx_up = $urandom_range(1, 6);
                end
            end else begin
                rx_cnt = 0;
            end
        end
        evt_in = e;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step(1'b0);
    endtask

    initial begin
        rst2_b = 1'b0;
        evt_in = 1'b0;
        ack_in = 1'b0;

        // Reset state
        run(3);
        chk("rst_req",  32'(req_out),  32'd0);
        chk("rst_done", 32'(done_out), 32'd0);
        chk("rst_ovf",  32'(ovf_out),  32'd0);
        chk("rst_pend", 32'(pend_out), 32'd0);
        chk("rst_busy", 32'(busy_out), 32'd0);

        // Single event
        rst2_b  = 1'b1;
        rx_auto = 1'b1; rx_up = 2; rx_dn = 2;
        base_done = done_cnt; base_ovf = ovf_cnt;
        run(4);
        step(1'b1);
        step(1'b0);
        chk("single_req_next", 32'(req_out),  32'd1);
        chk("single_pend",     32'(pend_out), 32'd0);
        chk("single_busy",     32'(busy_out), 32'd1);
        run(30);
        chk("single_done_cnt", 32'(done_cnt - base_done), 32'd1);
        chk("single_ovf_cnt",  32'(ovf_cnt - base_ovf),   32'd0);
        chk("single_busy_end", 32'(busy_out), 32'd0);
        chk("single_pend_end", 32'(pend_out), 32'd0);

        // Burst with slow receiver
        rx_up = 10; rx_dn = 10;
        base_done = done_cnt; base_ovf = ovf_cnt; pend_max = 0;
        for (int i = 0; i < 4; i++) step(1'b1);
        step(1'b0);
        run(200);
        chk("burst_pend_peak", 32'(pend_max), 32'd3);
        chk("burst_done_cnt",  32'(done_cnt - base_done), 32'd4);
        chk("burst_ovf_cnt",   32'(ovf_cnt - base_ovf),   32'd0);
        chk("burst_busy_end",  32'(busy_out), 32'd0);

        // Overflow: ack stuck low while in REQ
        rx_auto = 1'b0; ack_in = 1'b0;
        base_done = done_cnt; base_ovf = ovf_cnt;
        for (int i = 0; i < 17; i++) step(1'b1);
        step(1'b0);
        run(3);
        chk("ovf_pend_sat", 32'(pend_out), 32'd15);
        chk("ovf_pulses",   32'(ovf_cnt - base_ovf), 32'd1);
        chk("ovf_req_held", 32'(req_out), 32'd1);
        rx_auto = 1'b1; rx_up = 2; rx_dn = 2;
        run(400);
        chk("ovf_done_cnt", 32'(done_cnt - base_done), 32'd16);
        chk("ovf_pend_end", 32'(pend_out), 32'd0);
        chk("ovf_busy_end", 32'(busy_out), 32'd0);

        // Simultaneity: event in the IDLE cycle after ACKLO with pend=2
        rx_auto = 1'b0; ack_in = 1'b0;
        base_done = done_cnt;
        step(1'b1); step(1'b1); step(1'b1); step(1'b0);
        chk("sim_pend_pre", 32'(pend_out), 32'd2);
        ack_in = 1'b1;
        step(1'b0); step(1'b0);
        chk("sim_req_before_fall", 32'(req_out), 32'd1);
        step(1'b0);
        chk("sim_req_fall_3cyc", 32'(req_out), 32'd0);
        ack_in = 1'b0;
        step(1'b0); step(1'b0);
        chk("sim_done_early", 32'(done_out), 32'd0);
        step(1'b1);
        chk("sim_done_3cyc", 32'(done_out), 32'd1);
        step(1'b0);
        chk("sim_pend_hold", 32'(pend_out), 32'd2);
        chk("sim_req_restart", 32'(req_out), 32'd1);
        rx_auto = 1'b1;
        run(150);
        chk("sim_done_cnt", 32'(done_cnt - base_done), 32'd4);
        chk("sim_pend_end", 32'(pend_out), 32'd0);

        // Stale ack out of reset
        rx_auto = 1'b0;
        rst2_b = 1'b0; ack_in = 1'b1;
        run(2);
        rst2_b = 1'b1;
        base_done = done_cnt;
        run(3);
        step(1'b1); step(1'b1); step(1'b1); step(1'b0);
        run(2);
        chk("stale_req_low", 32'(req_out),  32'd0);
        chk("stale_pend",    32'(pend_out), 32'd3);
        chk("stale_busy",    32'(busy_out), 32'd1);
        ack_in = 1'b0;
        step(1'b0); step(1'b0);
        chk("stale_req_wait", 32'(req_out), 32'd0);
        step(1'b0);
        chk("stale_req_rise", 32'(req_out),  32'd1);
        chk("stale_pend_dec", 32'(pend_out), 32'd2);
        rx_auto = 1'b1;
        run(100);
        chk("stale_done_cnt", 32'(done_cnt - base_done), 32'd3);

        // Mid-operation asynchronous reset
        rx_auto = 1'b0; ack_in = 1'b0;
        for (int i = 0; i < 6; i++) step(1'b1);
        step(1'b0);
        chk("midrst_pend_pre", 32'(pend_out), 32'd5);
        chk("midrst_req_pre",  32'(req_out),  32'd1);
        #2;
        rst2_b = 1'b0;
        #1;
        chk("midrst_req_async",  32'(req_out),  32'd0);
        chk("midrst_pend_async", 32'(pend_out), 32'd0);
        chk("midrst_busy_async", 32'(busy_out), 32'd0);
        run(2);
        rst2_b = 1'b1;
        base_done = done_cnt;
        run(2);
        step(1'b1);
        step(1'b0);
        chk("midrst_req_next", 32'(req_out),  32'd1);
        chk("midrst_pend",     32'(pend_out), 32'd0);
        rx_auto = 1'b1; rx_up = 2; rx_dn = 2;
        run(40);
        chk("midrst_done_cnt", 32'(done_cnt - base_done), 32'd1);

        // Randomized traffic: every accepted event must produce exactly one
        // completed handshake; the event cap keeps the queue below saturation.
        rx_rand = 1'b1; rx_up = $urandom_range(1, 6); rx_dn = $urandom_range(1, 6);
        base_done = done_cnt; base_ovf = ovf_cnt; n_evt = 0;
        for (int i = 0; i < 300; i++) begin
            if ((n_evt < 12) && ($urandom_range(0, 9) == 0)) begin
                n_evt++;
                step(1'b1);
            end else begin
                step(1'b0);
            end
        end
        run(400);
        chk("rand_done_cnt", 32'(done_cnt - base_done), 32'(n_evt));
        chk("rand_ovf_cnt",  32'(ovf_cnt - base_ovf),   32'd0);
        chk("rand_pend_end", 32'(pend_out), 32'd0);
        chk("rand_busy_end", 32'(busy_out), 32'd0);
        chk("rand_req_end",  32'(req_out),  32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/cr_had_sync_tx.md
Name: cr_had_sync_tx

Overview:
- clk2-domain transmitter for a four-phase req/ack handshake. It carries event pulses from the clk2 domain to a receiver in the clk1 domain.
- Each clk2 event pulse is queued in a pending counter, then sent as one full req/ack cycle, so no pulse is lost regardless of the clock ratio.
- Sits in HAD next to the clk2-to-clk1 pulse synchronizer. This block is the reverse-direction, lossless sending end.

Parameters:
- CNT_W, 4, width of the pending-event counter; max queued events = 2^CNT_W-1 (default 15).

Ports:
- clk2  in  1  transmitter clock
- rst2_b  in  1  asynchronous active-low reset, clk2 domain
- evt_in  in  1  single-cycle event pulse, clk2 domain
- ack_in  in  1  acknowledge level from the clk1 receiver; asynchronous to clk2
- req_out  out  1  request level to the receiver; driven directly from a flop
- busy_out  out  1  high while a handshake is in flight or events are pending
- done_out  out  1  one-cycle pulse when a handshake completes
- ovf_out  out  1  one-cycle pulse when an event is dropped because the counter is full
- pend_out  out  CNT_W  current pending count (events accepted but not yet started)

Behaviour:
- Reset and clocking: rst2_b is an asynchronous, active-low reset on clk2; every flop is clocked by clk2.
- Reset values: req_out=0, done_out=0, ovf_out=0, pend_out=0, busy_out=0, state=IDLE, both ack sync flops=0.
- Ack synchronizer: ack_in passes through two clk2 flops (ack_ff1 -> ack_ff2). ack_s = ack_ff2. The FSM uses only ack_s.
- Start condition, evaluated each cycle: start = (state==IDLE) && !ack_s && (evt_in || pend!=0).
- Pending counter:
  - pend_next = pend + acc - start, where acc = evt_in && !(pend==MAX && !start).
  - ovf_out pulses in the cycle after evt_in arrives with pend==MAX and no start. That event is discarded and pend stays at MAX.
  - The counter never wraps.
- FSM states:
  - IDLE: on start, set req_out<=1 and go to REQ.
  - REQ: hold req_out=1. When ack_s==1, set req_out<=0 and go to ACKLO.
  - ACKLO: hold req_out=0. When ack_s==0, pulse done_out for one cycle and go to IDLE.
- Latency:
  - evt_in in cycle N with pend==0 in IDLE: req_out=1 in cycle N+1, and pend stays 0.
  - ack_in rise to req_out fall: 3 clk2 cycles (two sync flops plus the req flop).
  - ack_in fall to done_out: 3 cycles.
- Back-to-back: a new start is allowed in the IDLE cycle immediately after ACKLO, so a gap of at least one clk2 cycle with req_out=0 always exists between requests.
- Simultaneous events:
  - evt_in together with start: net pend change is 0.
  - evt_in during REQ or ACKLO: pend increments.
- Stale ack: if ack_s==1 while in IDLE (for example the receiver was not reset), the transmitter does not start. It waits until ack_s==0; events keep accumulating meanwhile.
- busy_out = (state!=IDLE) || (pend!=0), registered from next-state values, so it asserts the cycle after evt_in.
- Reset mid-operation: all state clears asynchronously and the queued events are lost. The receiver side must be reset together with rst2_b, or must drop ack; otherwise the stale-ack rule above holds requests off.
- Protocol invariant: req_out never rises while ack_s==1, and never falls while ack_s==0 in REQ.

Test Plan:
- Single event: reset, pulse evt_in at cycle 5, bench receiver raises ack 2 cycles after req and drops it 2 cycles after req falls -> req_out=1 at cycle 6, exactly one done_out pulse, pend_out stays 0, busy_out returns to 0.
- Burst: 4 back-to-back evt_in pulses with a slow receiver (ack delay 10 cycles) -> pend_out peaks at 3, 4 complete handshakes, 4 done_out pulses, no ovf_out.
- Overflow (CNT_W=4): 17 evt_in pulses while ack is stuck low in REQ -> pend_out saturates at 15, exactly one ovf_out pulse, 16 handshakes after ack resumes.
- Simultaneity: evt_in on the same cycle that the FSM returns to IDLE with pend=2 -> start fires and pend_out remains 2 the next cycle.
- Stale ack: hold ack_in=1 out of reset, pulse evt_in 3 times -> req_out stays 0 and pend_out=3. Drop ack_in -> req_out rises 3 cycles later.
- Mid-op reset: assert rst2_b low while in REQ with pend=5 -> req_out, pend_out and busy_out go to 0 immediately (asynchronously); after release with ack low, a new evt_in gives normal single-event timing.
